// File: rtl/pet_vram_pkg.sv
// Shared types and constants for the PET video RAM slot scheduler.
package pet_vram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        ACK
    } vram_fsm_e;

    typedef enum logic [1:0] {
        OWN_CPU,
        OWN_VIDEO,
        OWN_DMA
    } vram_owner_e;

    localparam logic [2:0] VIDEO_PHASE0 = 3'd0;
    localparam logic [2:0] VIDEO_PHASE1 = 3'd4;

    function automatic logic is_video_phase(input logic [2:0] phase, input logic dual_fetch);
        return (phase == VIDEO_PHASE0) || (dual_fetch && (phase == VIDEO_PHASE1));
    endfunction

endpackage

// File: rtl/pet_vram_post_buf.sv
// One-entry posted-write buffer: holds a CPU write that lost its slot until the
// bus frees up. A new capture while full simply overwrites (last write wins).
module pet_vram_post_buf #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              capture,
    input  logic              commit,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic [DATA_W-1:0] cap_data,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (capture) begin
            full <= 1'b1;
            addr <= cap_addr;
            data <= cap_data;
        end else if (commit) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/pet_vram_slot_scheduler.sv
// PET video RAM time-slot scheduler: shares the single VRAM port between CPU,
// video fetch and a DMA port; drives load_sr and emulates 2001 snow.
module pet_vram_slot_scheduler
    import pet_vram_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int DUAL_FETCH = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce_1m,
    input  logic              ce_8mp,
    input  logic              ce_8mn,
    input  logic              snow_mode,
    input  logic              cpu_sel,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [ADDR_W-1:0] video_addr,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic [DATA_W-1:0] vram_q,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [DATA_W-1:0] vram_wdata,
    output logic              cpu_owner,
    output logic              load_sr,
    output logic              snow_evt
);

    localparam logic DUAL = (DUAL_FETCH != 0);

    logic [2:0]        phase;
    logic              video_slot;
    vram_fsm_e         state;
    vram_owner_e       owner;
    logic              dma_we_q;
    logic [ADDR_W-1:0] dma_addr_q;
    logic [DATA_W-1:0] dma_wdata_q;
    logic              buf_full;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;

    // ce_1m restarts the phase in the same cycle, so decisions use this view.
    logic [2:0] phase_now;
    logic       slot_open;
    logic       dma_issue;
    logic       dma_accept;
    logic       post_commit;
    logic       post_capture;

    assign phase_now    = ce_1m ? 3'd0 : phase;
    assign slot_open    = ce_8mp && is_video_phase(phase_now, DUAL);
    assign dma_issue    = (state == ISSUE);
    assign dma_accept   = (state == IDLE) && ce_8mp && dma_req && !is_video_phase(phase_now, DUAL)
                          && !video_slot && !cpu_sel && !buf_full;
    assign post_commit  = buf_full && !video_slot && !dma_issue;
    assign post_capture = cpu_sel && cpu_we && ((video_slot && !snow_mode) || dma_issue);

    assign owner     = video_slot ? OWN_VIDEO : (dma_issue ? OWN_DMA : OWN_CPU);
    assign cpu_owner = (owner == OWN_CPU);

    pet_vram_post_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_post_buf (
        .clk      (clk),
        .reset_n  (reset_n),
        .capture  (post_capture),
        .commit   (post_commit),
        .cap_addr (cpu_addr),
        .cap_data (cpu_wdata),
        .full     (buf_full),
        .addr     (buf_addr),
        .data     (buf_data)
    );

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        vram_addr  = cpu_sel ? cpu_addr : video_addr;
        vram_we    = cpu_sel && cpu_we;
        vram_wdata = cpu_wdata;
        if (post_commit) begin
            vram_addr  = buf_addr;
            vram_we    = 1'b1;
            vram_wdata = buf_data;
        end else if (owner == OWN_VIDEO) begin
            if (snow_mode && cpu_sel) begin
                vram_addr = cpu_addr;
                vram_we   = cpu_we;
            end else begin
                vram_addr = video_addr;
                vram_we   = 1'b0;
            end
        end else if (owner == OWN_DMA) begin
            vram_addr  = dma_addr_q;
            vram_we    = dma_we_q;
            vram_wdata = dma_wdata_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase      <= 3'd0;
            video_slot <= 1'b0;
            load_sr    <= 1'b0;
            snow_evt   <= 1'b0;
        end else begin
            if (ce_1m) begin
                phase <= 3'd0;
            end else if (ce_8mn && (phase != 3'd7)) begin
                phase <= phase + 3'd1;
            end

            if (slot_open) begin
                video_slot <= 1'b1;
            end else if (ce_8mn) begin
                video_slot <= 1'b0;
            end

            if (ce_1m) begin
                load_sr <= 1'b1;
            end else if (ce_8mn) begin
                load_sr <= 1'b0;
            end

            snow_evt <= slot_open && snow_mode && cpu_sel;
        end
    end

    // DMA sequencer: the RAM read launched in ISSUE lands on vram_q in CAPTURE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            dma_we_q    <= 1'b0;
            dma_addr_q  <= '0;
            dma_wdata_q <= '0;
            dma_ack     <= 1'b0;
            dma_rdata   <= '0;
        end else begin
            dma_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (dma_accept) begin
                        dma_we_q    <= dma_we;
                        dma_addr_q  <= dma_addr;
                        dma_wdata_q <= dma_wdata;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    if (!dma_we_q) begin
                        dma_rdata <= vram_q;
                    end
                    dma_ack <= 1'b1;
                    state   <= ACK;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pet_vram_slot_scheduler.sv
// Randomized bench for pet_vram_slot_scheduler against a microsecond-schedule
// reference model plus a behavioural VRAM image.
module tb_pet_vram_slot_scheduler;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ce_1m = 1'b0, ce_8mp = 1'b0, ce_8mn = 1'b0;
    logic          snow_mode = 1'b0;
    logic          cpu_sel = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [AW-1:0] video_addr = '0;
    logic          dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [DW-1:0] dma_wdata = '0;
    logic [DW-1:0] vram_q = '0;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;
    logic [AW-1:0] vram_addr;
    logic          vram_we;
    logic [DW-1:0] vram_wdata;
    logic          cpu_owner, load_sr, snow_evt;

    logic          zero_req = 1'b0;
    logic          dack_d, vwe_d, owner_d, lsr_d, snow_d;
    logic [DW-1:0] drdata_d, vwd_d;
    logic [AW-1:0] vaddr_d;

    always #5 clk = ~clk;

    pet_vram_slot_scheduler #(.ADDR_W(AW), .DATA_W(DW), .DUAL_FETCH(0)) dut (
        .clk(clk), .reset_n(reset_n), .ce_1m(ce_1m), .ce_8mp(ce_8mp), .ce_8mn(ce_8mn),
        .snow_mode(snow_mode), .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .video_addr(video_addr), .dma_req(dma_req), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .vram_q(vram_q), .dma_ack(dma_ack),
        .dma_rdata(dma_rdata), .vram_addr(vram_addr), .vram_we(vram_we),
        .vram_wdata(vram_wdata), .cpu_owner(cpu_owner), .load_sr(load_sr), .snow_evt(snow_evt)
    );

    pet_vram_slot_scheduler #(.ADDR_W(AW), .DATA_W(DW), .DUAL_FETCH(1)) dut_dual (
        .clk(clk), .reset_n(reset_n), .ce_1m(ce_1m), .ce_8mp(ce_8mp), .ce_8mn(ce_8mn),
        .snow_mode(snow_mode), .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .video_addr(video_addr), .dma_req(zero_req), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .vram_q(vram_q), .dma_ack(dack_d),
        .dma_rdata(drdata_d), .vram_addr(vaddr_d), .vram_we(vwe_d),
        .vram_wdata(vwd_d), .cpu_owner(owner_d), .load_sr(lsr_d), .snow_evt(snow_d)
    );

    // Synchronous read-first VRAM; every cell starts as a PET space (0x20).
    logic [DW-1:0] ram [1024];
    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h20;
        forever begin
            @(posedge clk);
            vram_q <= ram[vram_addr];
            if (vram_we) ram[vram_addr] = vram_wdata;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: position inside the 64-clk microsecond, RAM image,
    // pending posted write and the DMA transaction in flight.
    int            ofs = 0;
    logic [DW-1:0] ref_mem [1024];
    logic          pv = 1'b0;
    logic [AW-1:0] pa = '0;
    logic [DW-1:0] pd = '0;
    int            dcnt = 0;
    logic          dwe = 1'b0;
    logic [AW-1:0] da = '0;
    logic [DW-1:0] dwd = '0;
    logic [DW-1:0] rd_hold = '0;
    logic [DW-1:0] exp_rdata = '0;
    logic          snow_open = 1'b0;
    logic          saw_ack = 1'b0;

    function automatic logic [AW-1:0] rnd_addr();
        int r = int'($urandom_range(0, 9));
        if (r < 8) return AW'(r);
        return (r == 8) ? 10'h3E8 : 10'h3FF;
    endfunction

    // One clock: drive enables for this microsecond offset, check, advance model.
    task automatic tick();
        logic          slot, slot_d, issue, commit, accept, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        ce_1m  = (ofs == 0);
        ce_8mp = (ofs % 8 == 0);
        ce_8mn = (ofs % 8 == 4);
        #1;
        slot   = (ofs >= 1) && (ofs <= 4);
        slot_d = slot || ((ofs >= 33) && (ofs <= 36));
        issue  = (dcnt == 3);
        commit = pv && !slot && !issue;
        e_addr = video_addr;
        e_we   = 1'b0;
        e_wd   = cpu_wdata;
        if (commit) begin
            e_addr = pa; e_we = 1'b1; e_wd = pd;
        end else if (slot) begin
            if (snow_mode && cpu_sel) begin
                e_addr = cpu_addr; e_we = cpu_we;
            end
        end else if (issue) begin
            e_addr = da; e_we = dwe; e_wd = dwd;
        end else if (cpu_sel) begin
            e_addr = cpu_addr; e_we = cpu_we;
        end

        check("vram_addr", 32'(vram_addr), 32'(e_addr));
        check("vram_we", 32'(vram_we), 32'(e_we));
        if (e_we) check("vram_wdata", 32'(vram_wdata), 32'(e_wd));
        check("cpu_owner", 32'(cpu_owner), 32'(!(slot || issue)));
        check("cpu_owner_dual", 32'(owner_d), 32'(!slot_d));
        check("load_sr", 32'(load_sr), 32'(slot));
        check("snow_evt", 32'(snow_evt), 32'((ofs == 1) && snow_open));
        check("dma_ack", 32'(dma_ack), 32'(dcnt == 1));
        check("dma_rdata", 32'(dma_rdata), 32'(exp_rdata));
        saw_ack = dma_ack;

        accept = (dcnt == 0) && ce_8mp && (ofs != 0) && dma_req && !cpu_sel && !pv;
        if (issue && !dwe) rd_hold = ref_mem[da];
        if ((dcnt == 2) && !dwe) exp_rdata = rd_hold;
        if (e_we) ref_mem[e_addr] = e_wd;
        if (cpu_sel && cpu_we && ((slot && !snow_mode) || issue)) begin
            pv = 1'b1; pa = cpu_addr; pd = cpu_wdata;
        end else if (commit) begin
            pv = 1'b0;
        end
        if (ofs == 0) snow_open = snow_mode && cpu_sel;
        if (dcnt != 0) begin
            dcnt--;
        end else if (accept) begin
            dcnt = 3; da = dma_addr; dwe = dma_we; dwd = dma_wdata;
        end
        @(negedge clk);
        ofs = (ofs + 1) % 64;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        ce_1m = 1'b0; ce_8mp = 1'b0; ce_8mn = 1'b0;
        snow_mode = 1'b0; cpu_sel = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        video_addr = '0; dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        #1;
        check("rst_cpu_owner", 32'(cpu_owner), 32'd1);
        check("rst_cpu_owner_dual", 32'(owner_d), 32'd1);
        check("rst_dma_ack", 32'(dma_ack), 32'd0);
        check("rst_dma_rdata", 32'(dma_rdata), 32'd0);
        check("rst_load_sr", 32'(load_sr), 32'd0);
        check("rst_snow_evt", 32'(snow_evt), 32'd0);
        check("rst_vram_we", 32'(vram_we), 32'd0);
        check("rst_vram_addr", 32'(vram_addr), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pv = 1'b0; dcnt = 0; exp_rdata = '0; snow_open = 1'b0; saw_ack = 1'b0;
        ofs = 0;
    endtask

    task automatic dma_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
        do begin
            tick();
            n++;
        end while (!saw_ack && n < 200);
        check("dma_done", 32'(saw_ack), 32'd1);
        dma_req = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h20;
        @(negedge clk);
        apply_reset();

        // Quiet microsecond: only the slot schedule and load_sr move.
        repeat (64) tick();

        // Non-snow CPU write inside the video slot is posted until slot close.
        snow_mode = 1'b0; video_addr = 10'h123;
        while (ofs != 2) tick();
        cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3E8; cpu_wdata = 8'h41;
        tick();
        cpu_sel = 1'b0; cpu_we = 1'b0;
        tick(); tick();
        check("posted_we", 32'(vram_we), 32'd1);
        check("posted_addr", 32'(vram_addr), 32'h3E8);
        check("posted_data", 32'(vram_wdata), 32'h41);

        // Snow mode: the CPU takes the slot and snow_evt fires once.
        while (ofs != 0) tick();
        snow_mode = 1'b1; cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3E8; cpu_wdata = 8'h42;
        tick();
        check("snow_addr", 32'(vram_addr), 32'h3E8);
        check("snow_we", 32'(vram_we), 32'd1);
        check("snow_evt_pulse", 32'(snow_evt), 32'd1);
        repeat (4) tick();
        cpu_sel = 1'b0; cpu_we = 1'b0; snow_mode = 1'b0;

        // DMA read of an untouched cell.
        dma_xfer(1'b0, 10'h000, 8'h00);
        check("dma_rd_000", 32'(dma_rdata), 32'h20);

        // DMA write raised late in the microsecond must skip phase 0.
        while (ofs != 60) tick();
        dma_xfer(1'b1, 10'h3FF, 8'hA5);
        check("dma_wr_after_ph0", 32'(ofs), 32'd12);
        dma_xfer(1'b0, 10'h3FF, 8'h00);
        check("dma_rd_3ff", 32'(dma_rdata), 32'hA5);

        // Reset in the middle of a DMA read with a deferred CPU write pending.
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 10'h005;
        n = 0;
        while (dcnt != 3 && n < 200) begin
            tick();
            n++;
        end
        check("issue_owner", 32'(cpu_owner), 32'd0);
        cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h007; cpu_wdata = 8'h77;
        tick();
        cpu_sel = 1'b0; cpu_we = 1'b0;
        apply_reset();
        repeat (64) tick();

        // Randomized traffic from all three requesters.
        for (int c = 0; c < 3000; c++) begin
            if (ofs == 0) snow_mode = ($urandom_range(0, 3) == 0);
            cpu_sel    = ($urandom_range(0, 3) == 0);
            cpu_we     = 1'($urandom_range(0, 1));
            cpu_addr   = rnd_addr();
            cpu_wdata  = 8'($urandom);
            video_addr = 10'($urandom);
            if (dma_req && saw_ack && ($urandom_range(0, 3) != 0)) begin
                dma_req = 1'b0;
            end else if (!dma_req && ($urandom_range(0, 7) == 0)) begin
                dma_req   = 1'b1;
                dma_we    = 1'($urandom_range(0, 1));
                dma_addr  = rnd_addr();
                dma_wdata = 8'($urandom);
            end
            tick();
        end
        dma_req = 1'b0; cpu_sel = 1'b0; cpu_we = 1'b0;
        repeat (8) tick();

        n = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) n++;
        check("ram_image_mismatches", 32'(n), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
